dmem_dump_controller: RTL and testbench
=======================================

// Module: dmem_dump_controller
// PURPOSE
//  Owns the data-memory port and shares it between the core and a halt/dump engine.
//  In normal run the core's load/store bus passes straight through to data memory.
//  On halt (fetched instruction equals HALT_INST, or dump_req asserted) the block
//  stalls the core, takes the port, and streams words 0..DEPTH-1 to a dump sink
//  over a valid/ready handshake, replacing the bench-side forced-address dump.
// PARAMETERS
//  DEPTH      256        number of 32-bit words dumped (indices 0..DEPTH-1)
//  AW         32         byte-address width of the data-memory port
//  DW         32         data width
//  HALT_INST  32'h0      instruction encoding that triggers halt
// PORTS
//  clk         in   1    clock, rising edge
//  rst         in   1    asynchronous reset, active-low
//  inst        in   32   instruction currently fetched by the core
//  dump_req    in   1    external halt+dump request, level, sampled in RUN
//  cpu_addr    in   AW   core data address (byte)
//  cpu_we      in   1    core store enable
//  cpu_wdata   in   DW   core store data
//  cpu_rdata   out  DW   load data back to core (= mem_rdata, all states)
//  mem_addr    out  AW   data-memory address
//  mem_we      out  1    data-memory write enable
//  mem_wdata   out  DW   data-memory write data
//  mem_rdata   in   DW   data-memory read data, valid 1 cycle after mem_addr (sync read)
//  halt        out  1    stall core (PC and register file hold)
//  dump_valid  out  1    dump_data/dump_index valid
//  dump_ready  in   1    sink accepts word
//  dump_index  out  8    word index 0..DEPTH-1 (clog2(DEPTH) bits)
//  dump_data   out  DW   word at byte address dump_index*4
//  dump_done   out  1    all DEPTH words accepted; sticky until reset
// BEHAVIOUR
//  Reset (rst=0, async): state RUN, idx=0, halt=0, dump_valid=0, dump_done=0,
//   dump_data=0, dump_index=0; RUN mux applies immediately.
//  States: RUN -> QUIESCE -> RD -> OUT -> (RD | DONE). DONE is terminal.
//  RUN: mem_addr/we/wdata = cpu_*. If inst==HALT_INST or dump_req at posedge -> QUIESCE.
//   A store presented in the trigger cycle is written (mux still CPU that cycle).
//  QUIESCE (1 cycle): halt=1, mem_we=0, mem_addr=0; lets last write settle. -> RD.
//  RD (1 cycle): halt=1, mem_we=0, mem_addr={idx,2'b00} zero-extended to AW. -> OUT.
//  OUT: capture mem_rdata into dump_data on entry; dump_valid=1, dump_index=idx;
//   data/index held stable while dump_valid & !dump_ready.
//   On dump_valid & dump_ready: if idx==DEPTH-1 -> DONE, else idx<=idx+1 -> RD.
//  DONE: halt=1, dump_valid=0, dump_done=1, mem_we=0; ignores inst/dump_req.
//  cpu_we is ignored (never reaches memory) in every state except RUN.
//  Throughput: 2 cycles/word with dump_ready tied high; dump of 256 words =
//   1 (QUIESCE) + 512 cycles from trigger to dump_done.
//  idx never wraps: compare against DEPTH-1 before increment.
//  Reset mid-dump: abort, return to RUN with idx=0; no partial done flag.
//  dump_ready asserted without dump_valid: no effect.
// STRUCTURE
//  Shared package/header: state encodings (ST_RUN..ST_DONE), HALT_INST default,
//   dump word-to-byte shift constant (2).
//  One sub-module natural: dmem_port_mux (combinational CPU/dump select of
//   addr/we/wdata on sel=halt). FSM, idx counter, capture register in top.
// TESTING
//  1 Store-then-halt: cpu store 0xDEADBEEF @0x10 with inst=0 same cycle -> word 4
//    dumped as 0xDEADBEEF; halt rises the next cycle.
//  2 Full dump, dump_ready=1: preload mem[i]=i*3 -> 256 handshakes, index 0..255 in order,
//    data i*3, dump_done high exactly 513 cycles after trigger edge.
//  3 Backpressure: dump_ready toggles 1-of-3 cycles -> data/index stable while
//    stalled, no word skipped or repeated, 256 accepts total.
//  4 Isolation: during dump drive cpu_we=1, cpu_addr=0x0, cpu_wdata=0xFFFFFFFF ->
//    mem_we stays 0; word 0 dumped with its preloaded value.
//  5 Async reset at idx=100: rst low mid-cycle -> outputs zero immediately, state RUN,
//    cpu traffic passes; retrigger restarts at index 0.
//  6 dump_req=1 with inst!=0 -> same dump sequence; dump_req after DONE ignored.

Source files
------------

// File: rtl/dmem_dump_controller_pkg.sv
// Shared encodings and constants for the data-memory halt/dump controller.
package dmem_dump_controller_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_QUIESCE = 3'd1,
    ST_RD      = 3'd2,
    ST_OUT     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [31:0] HALT_INST_DEF = 32'h0000_0000;

  // Word index to byte address: 32-bit words.
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/dmem_port_mux.sv
// Selects whether the core or the dump engine drives the data-memory port.
// Writes are blocked outright while the dump engine owns the port.
module dmem_port_mux #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          sel,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [AW-1:0] dump_addr,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata
);

  assign mem_addr  = sel ? dump_addr : cpu_addr;
  assign mem_we    = sel ? 1'b0      : cpu_we;
  assign mem_wdata = sel ? '0        : cpu_wdata;

endmodule

// File: rtl/dmem_dump_controller.sv
// Shares the data-memory port between the core and a halt-triggered dump engine
// that streams words 0..DEPTH-1 over valid/ready, two cycles per word unstalled.
module dmem_dump_controller
  import dmem_dump_controller_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter int          AW        = 32,
  parameter int          DW        = 32,
  parameter logic [31:0] HALT_INST = HALT_INST_DEF,
  localparam int         IW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   inst,
  input  logic          dump_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          halt,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [IW-1:0] dump_index,
  output logic [DW-1:0] dump_data,
  output logic          dump_done
);

  state_t        state;
  logic [IW-1:0] idx;
  logic          first;
  logic [DW-1:0] hold;
  logic [AW-1:0] dump_addr;

  // Address stays on the current word through OUT so the read data is steady.
  assign dump_addr  = (state == ST_RD || state == ST_OUT) ? (AW'(idx) << WORD_SHIFT) : '0;
  assign cpu_rdata  = mem_rdata;
  assign dump_index = idx;
  // The sync read lands in the first OUT cycle; after that the held copy is shown.
  assign dump_data  = first ? mem_rdata : hold;

  dmem_port_mux #(
    .AW (AW),
    .DW (DW)
  ) u_mux (
    .sel       (halt),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .dump_addr (dump_addr),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RUN;
      idx        <= '0;
      halt       <= 1'b0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      first      <= 1'b0;
      hold       <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (inst == HALT_INST || dump_req) begin
            state <= ST_QUIESCE;
            halt  <= 1'b1;
          end
        end
        ST_QUIESCE: state <= ST_RD;
        ST_RD: begin
          state      <= ST_OUT;
          dump_valid <= 1'b1;
          first      <= 1'b1;
        end
        ST_OUT: begin
          first <= 1'b0;
          if (first) hold <= mem_rdata;
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (idx == IW'(DEPTH - 1)) begin
              state     <= ST_DONE;
              dump_done <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_RD;
            end
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_controller.sv
// Scoreboard bench: expected dump words are queued from a memory model; a monitor checks each offered word.
module tb_dmem_dump_controller;

  typedef struct {
    logic [7:0]  idx;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        dump_req;
  logic [31:0] cpu_addr;
  logic        cpu_we;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        halt;
  logic        dump_valid;
  logic        dump_ready;
  logic [7:0]  dump_index;
  logic [31:0] dump_data;
  logic        dump_done;

  logic [31:0] mem [256];
  logic [31:0] exp_mem [256];
  logic        pre;
  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          accepts = 0;
  int          cyc;
  int          k;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  dmem_dump_controller dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .dump_req   (dump_req),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .halt       (halt),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_index (dump_index),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  // Synchronous-read data memory with a bulk preload of mem[i] = i*3.
  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i * 3);
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every offered word must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (halt) check("mem_we_blocked", 32'(mem_we), 32'd0);
    if (dump_valid) begin
      if (q.size() == 0) begin
        check("unexpected_word", 32'(dump_index), 32'hFFFF_FFFF);
      end else begin
        check("dump_index", 32'(dump_index), 32'(q[0].idx));
        check("dump_data", dump_data, q[0].dat);
        if (dump_ready) begin
          void'(q.pop_front());
          accepts++;
        end
      end
    end
  end

  task automatic preload();
    @(posedge clk); #1 pre = 1'b1;
    @(posedge clk); #1 pre = 1'b0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'(i * 3);
  endtask

  task automatic push_all();
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      e.idx = 8'(i);
      e.dat = exp_mem[i];
      q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    q.delete();
    accepts = 0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
  endtask

  // Counts posedges after the trigger edge until dump_done; caller sits at trigger edge + 1.
  task automatic wait_done(input string name, input int want);
    cyc = 0;
    while (!dump_done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(name, 32'(cyc), 32'(want));
  endtask

  initial begin
    rst = 1'b0; pre = 1'b0; inst = NOP; dump_req = 1'b0;
    cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0; dump_ready = 1'b0;

    // Reset state and passthrough
    #12;
    cpu_addr = 32'h0000_0040; cpu_we = 1'b1; cpu_wdata = 32'h1234_5678;
    #1;
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_done", 32'(dump_done), 32'd0);
    check("rst_data", dump_data, 32'd0);
    check("rst_index", 32'(dump_index), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0000_0040);
    check("rst_mem_wdata", mem_wdata, 32'h1234_5678);
    cpu_we = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    // Store-then-halt, full unstalled dump, isolation
    preload();
    cpu_addr = 32'h10; cpu_we = 1'b1; cpu_wdata = 32'hDEAD_BEEF; inst = 32'h0; dump_ready = 1'b1;
    exp_mem[4] = 32'hDEAD_BEEF;
    push_all();
    @(negedge clk);
    check("trig_mem_we", 32'(mem_we), 32'd1);
    check("trig_halt", 32'(halt), 32'd0);
    @(posedge clk); #1;
    inst = NOP; cpu_addr = 32'h0; cpu_we = 1'b1; cpu_wdata = 32'hFFFF_FFFF;
    check("halt_next", 32'(halt), 32'd1);
    wait_done("done_latency", 513);
    cpu_we = 1'b0;
    check("accepts_full", 32'(accepts), 32'd256);
    check("queue_empty_full", 32'(q.size()), 32'd0);

    // Backpressure: ready one cycle in three
    do_reset();
    preload();
    push_all();
    dump_ready = 1'b0;
    inst = 32'h0;
    @(posedge clk); #1 inst = NOP;
    k = 0;
    while (!dump_done && k < 4000) begin
      dump_ready = (k % 3 == 0);
      @(posedge clk); #1;
      k++;
    end
    check("bp_done", 32'(dump_done), 32'd1);
    check("accepts_bp", 32'(accepts), 32'd256);
    check("queue_empty_bp", 32'(q.size()), 32'd0);

    // Async reset at index 100, then dump_req retrigger
    do_reset();
    preload();
    push_all();
    dump_ready = 1'b1; dump_req = 1'b1;
    @(posedge clk); #1 dump_req = 1'b0;
    k = 0;
    while (!(dump_valid && dump_index == 8'd100) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("reached_idx100", 32'(dump_index), 32'd100);
    #2 rst = 1'b0;
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h55;
    #1;
    q.delete();
    accepts = 0;
    check("mid_rst_halt", 32'(halt), 32'd0);
    check("mid_rst_valid", 32'(dump_valid), 32'd0);
    check("mid_rst_done", 32'(dump_done), 32'd0);
    check("mid_rst_index", 32'(dump_index), 32'd0);
    check("mid_rst_data", dump_data, 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd1);
    check("mid_rst_mem_addr", mem_addr, 32'h20);
    check("mid_rst_mem_wdata", mem_wdata, 32'h55);
    @(posedge clk); #1;
    exp_mem[8] = 32'h55;
    cpu_we = 1'b0;
    rst = 1'b1;
    push_all();
    dump_req = 1'b1;
    @(posedge clk); #1;
    wait_done("done_latency_req", 513);
    check("accepts_req", 32'(accepts), 32'd256);
    check("queue_empty_req", 32'(q.size()), 32'd0);
    inst = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_done_valid", 32'(dump_valid), 32'd0);
      check("post_done_flag", 32'(dump_done), 32'd1);
      check("post_done_halt", 32'(halt), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
